// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 8-digit common-anode 7-segment scan driver with blanking, PWM and frame snapshot
module sseg_scan_driver #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DUTY_W       = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_in0,
    input  logic [7:0]        i_in1,
    input  logic [7:0]        i_in2,
    input  logic [7:0]        i_in3,
    input  logic [7:0]        i_in4,
    input  logic [7:0]        i_in5,
    input  logic [7:0]        i_in6,
    input  logic [7:0]        i_in7,
    input  logic [7:0]        i_dig_en,
    input  logic [DUTY_W-1:0] i_bright,
    output logic [7:0]        o_an,
    output logic [7:0]        o_sseg,
    output logic              o_frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_slot_cnt;
    logic [2:0]        r_idx;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [7:0]        r_shadow [8];
    logic [7:0]        r_an;
    logic [7:0]        r_sseg;
    logic              r_frame_tick;

    logic [7:0]        w_in [8];
    logic [2:0]        w_first;
    logic [2:0]        w_next;
    logic              w_any_en;
    logic              w_slot_end;
    logic              w_frame_start;
    logic              w_lit;

    always_comb begin
        w_in[0] = i_in0;
        w_in[1] = i_in1;
        w_in[2] = i_in2;
        w_in[3] = i_in3;
        w_in[4] = i_in4;
        w_in[5] = i_in5;
        w_in[6] = i_in6;
        w_in[7] = i_in7;
    end

    // Descending loops so the last hit is the lowest digit / nearest digit after r_idx.
    always_comb begin
        w_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_dig_en[i]) w_first = 3'(i);
        end
        w_next = r_idx;
        for (int k = 8; k >= 1; k--) begin
            if (i_dig_en[r_idx + 3'(k)]) w_next = r_idx + 3'(k);
        end
    end

    assign w_any_en      = (i_dig_en != 8'h00);
    assign w_slot_end    = (r_state == S_DRIVE) && (r_slot_cnt == SLOT_LAST);
    assign w_frame_start = ((r_state == S_IDLE) && w_any_en) ||
                           (w_slot_end && w_any_en && (w_next <= r_idx));
    assign w_lit         = (r_state == S_DRIVE) && (r_pwm_cnt < i_bright);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_slot_cnt   <= '0;
            r_idx        <= 3'd0;
            r_pwm_cnt    <= '0;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'hFF;
        end else begin
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                for (int i = 0; i < 8; i++) r_shadow[i] <= w_in[i];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_en) begin
                        r_idx      <= w_first;
                        r_slot_cnt <= '0;
                        r_state    <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                    if (r_slot_cnt == BLANK_LAST) begin
                        r_pwm_cnt <= '0;
                        r_state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_pwm_cnt <= r_pwm_cnt + 1'b1;
                    if (w_slot_end) begin
                        r_slot_cnt <= '0;
                        if (!w_any_en) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= w_next;
                            r_state <= S_BLANK;
                        end
                    end else begin
                        r_slot_cnt <= r_slot_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage registered so an/sseg never glitch on decode of the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an   <= 8'hFF;
            r_sseg <= 8'hFF;
        end else if (w_lit) begin
            r_an   <= ~(8'd1 << r_idx);
            r_sseg <= r_shadow[r_idx];
        end else begin
            r_an   <= 8'hFF;
            r_sseg <= 8'hFF;
        end
    end

    assign o_an         = r_an;
    assign o_sseg       = r_sseg;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - scoreboard bench for sseg_scan_driver against a slot/frame reference model
module tb_sseg_scan_driver;

    localparam int SLOT  = 16;
    localparam int BLANK = 2;
    localparam int DW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_v [8];
    logic [7:0]    dig_en = 8'h00;
    logic [DW-1:0] bright = '0;
    logic [7:0]    an;
    logic [7:0]    sseg;
    logic          frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] sseg;
        logic       tick;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    sseg_scan_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .DUTY_W(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in0(in_v[0]), .i_in1(in_v[1]), .i_in2(in_v[2]), .i_in3(in_v[3]),
        .i_in4(in_v[4]), .i_in5(in_v[5]), .i_in6(in_v[6]), .i_in7(in_v[7]),
        .i_dig_en(dig_en), .i_bright(bright),
        .o_an(an), .o_sseg(sseg), .o_frame_tick(frame_tick)
    );

    // Reference: a digit slot is SLOT clocks, the first BLANK dark, then a PWM
    // phase that repeats every 2^DW clocks; patterns are latched at each frame start.
    bit         m_act = 0;
    int         m_pos = 0;
    int         m_dig = 0;
    logic [7:0] m_snap [8];

    always @(posedge clk) begin
        exp_t e;
        bit   lit;
        int   nd;
        if (rst) begin
            m_act = 0; m_pos = 0; m_dig = 0;
            for (int i = 0; i < 8; i++) m_snap[i] = 8'hFF;
            e = '{an: 8'hFF, sseg: 8'hFF, tick: 1'b0};
        end else begin
            lit = m_act && (m_pos >= BLANK) && (((m_pos - BLANK) % (1 << DW)) < int'(bright));
            e.an   = lit ? ~(8'd1 << m_dig) : 8'hFF;
            e.sseg = lit ? m_snap[m_dig] : 8'hFF;
            e.tick = 1'b0;
            if (!m_act) begin
                if (dig_en != 0) begin
                    for (int i = 0; i < 8; i++) if (dig_en[i]) begin m_dig = i; break; end
                    for (int i = 0; i < 8; i++) m_snap[i] = in_v[i];
                    e.tick = 1'b1;
                    m_act = 1; m_pos = 0;
                end
            end else if (m_pos == SLOT - 1) begin
                m_pos = 0;
                if (dig_en == 0) begin
                    m_act = 0;
                end else begin
                    nd = m_dig;
                    for (int k = 1; k <= 8; k++) if (dig_en[(m_dig + k) % 8]) begin nd = (m_dig + k) % 8; break; end
                    if (nd <= m_dig) begin
                        e.tick = 1'b1;
                        for (int i = 0; i < 8; i++) m_snap[i] = in_v[i];
                    end
                    m_dig = nd;
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (an !== e.an || sseg !== e.sseg || frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL scan t=%0t an=%h sseg=%h tick=%b expected an=%h sseg=%h tick=%b",
                         $time, an, sseg, frame_tick, e.an, e.sseg, e.tick);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] val, input bit eq, input string nm);
        int c = 0;
        while ((eq ? (an !== val) : (an === val)) && c < 400) begin
            @(negedge clk); c++;
        end
        if (c >= 400) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout an=%h required %s %h", nm, an, eq ? "==" : "!=", val);
        end
    endtask

    task automatic measure_period(input int want, input string nm);
        int c = 0;
        while (frame_tick !== 1'b1 && c < 400) begin @(negedge clk); c++; end
        c = 0;
        do begin @(negedge clk); c++; end while (frame_tick !== 1'b1 && c < 400);
        n_cmp++;
        if (c != want) begin
            n_err++;
            $display("FAIL %s frame period %0d required %0d", nm, c, want);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_v[i] = 8'hFF;
        run(3);
        rst = 1'b0;
        run(20);

        for (int i = 0; i < 8; i++) in_v[i] = 8'h10 + 8'(i);
        in_v[2] = 8'hC0;
        bright = 2'd3;
        dig_en = 8'hFF;
        measure_period(128, "full_scan");

        in_v[2] = 8'h12;
        wait_an(8'hFF, 1'b0, "reset_mid_drive");
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (an !== 8'hFF || sseg !== 8'hFF) begin
            n_err++;
            $display("FAIL async_reset an=%h sseg=%h required an=ff sseg=ff", an, sseg);
        end
        dig_en = 8'h00;
        @(negedge clk);
        #1 rst = 1'b0;
        run(20);

        dig_en = 8'b1000_0101;
        measure_period(48, "skip");

        in_v[2] = 8'hC0;
        run(60);
        wait_an(8'hFE, 1'b1, "tear_free");
        in_v[2] = 8'hF9;
        run(120);

        bright = 2'd0;
        run(60);
        bright = 2'd1;
        run(60);
        wait_an(8'hFF, 1'b0, "bright_mid");
        run(3);
        bright = 2'd2;
        run(5);
        bright = 2'd3;
        run(30);

        dig_en = 8'hFF;
        wait_an(8'hFF, 1'b0, "mask_zero");
        dig_en = 8'h00;
        run(40);
        dig_en = 8'h10;
        run(40);

        for (int it = 0; it < 30; it++) begin
            dig_en = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            bright = DW'($urandom);
            for (int i = 0; i < 8; i++) in_v[i] = 8'($urandom);
            run($urandom_range(10, 100));
            bright = DW'($urandom);
            in_v[$urandom_range(0, 7)] = 8'($urandom);
            run($urandom_range(10, 120));
        end

        run(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
